// File: rtl/arb_pkg.sv
// Shared helpers and defaults for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned MAX_HOLD_DEF = 8;

  // Width needed to hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first requester at or after start, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  // Scan start, start+1, ..., N-1, 0, ... and keep the first hit.
  always_comb begin
    int unsigned j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with bounded hold time.
// Optional macro ARB_PRIO0_EN gives requester 0 absolute, preempting priority;
// owner 0 is then exempt from the hold limit and its grants leave the
// rotation pointer untouched.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  localparam int unsigned IDXW    = idx_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant_onehot,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam int unsigned     HW        = idx_width(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N-1:0]    onehot_d;
  logic [IDXW-1:0] idx_d;
  logic            valid_d;

  logic [IDXW-1:0] pick_idx;
  logic            pick_found;

  logic            grant_new;
  logic [IDXW-1:0] new_idx;
  logic            prio_take;
  logic            keep_exempt;
  logic            own_req;
  logic            others;
  logic            hold_left;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .start (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ARB_PRIO0_EN
  // Requester 0 preempts any other owner (or an idle arbiter) immediately.
  always_comb begin
    prio_take   = req[0] && !(grant_valid && (grant_idx == '0));
    keep_exempt = grant_idx == '0;
  end
`else
  // Requester 0 is an ordinary round-robin participant.
  always_comb begin
    prio_take   = 1'b0;
    keep_exempt = 1'b0;
  end
`endif

  // Decide keep / handover / idle and compute next grant, pointer and hold count.
  always_comb begin
    valid_d   = grant_valid;
    idx_d     = grant_idx;
    onehot_d  = grant_onehot;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_new = 1'b0;
    new_idx   = pick_idx;
    own_req   = req[grant_idx];
    others    = |(req & ~grant_onehot);
    hold_left = hold_q < HOLD_LAST;

    if (prio_take) begin
      grant_new = 1'b1;
      new_idx   = '0;
    end else if (!grant_valid) begin
      grant_new = pick_found;
    end else if (own_req && (hold_left || !others || keep_exempt)) begin
      if (hold_left) hold_d = hold_q + 1'b1;
    end else if (pick_found) begin
      // Direct handover; with hold expired ptr already points past the owner.
      grant_new = 1'b1;
    end else begin
      valid_d  = 1'b0;
      idx_d    = '0;
      onehot_d = '0;
    end

    if (grant_new) begin
      valid_d           = 1'b1;
      idx_d             = new_idx;
      onehot_d          = '0;
      onehot_d[new_idx] = 1'b1;
      hold_d            = '0;
      if (!prio_take) ptr_d = (new_idx == IDX_LAST) ? '0 : new_idx + 1'b1;
    end
  end

  // Registered outputs and arbitration state; reset drops any grant at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr_q        <= '0;
      hold_q       <= '0;
    end else begin
      grant_valid  <= valid_d;
      grant_idx    <= idx_d;
      grant_onehot <= onehot_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n with N=4, MAX_HOLD=4.
// The priority step adapts to ARB_PRIO0_EN so both builds are exercised.
module tb_rr_arbiter_n;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant_onehot;
  logic [1:0]   grant_idx;
  logic         grant_valid;

  int total = 0;
  int bad   = 0;
  bit inv_on = 1'b0;

  rr_arbiter_n #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic v, input logic [1:0] i);
    logic [6:0] obs;
    logic [6:0] exp;
    logic [3:0] oh;
    oh = 4'b0000;
    if (v) oh[i] = 1'b1;
    exp = {v, i, oh};
    obs = {grant_valid, grant_idx, grant_onehot};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  // Every cycle: one-hot iff valid, onehot[idx] set, idx 0 when idle.
  always @(negedge clk) begin
    if (inv_on) begin
      total++;
      assert (($countones(grant_onehot) == (grant_valid ? 1 : 0)) &&
              (!grant_valid || grant_onehot[grant_idx]) &&
              (grant_valid || grant_idx == 2'd0))
      else begin
        bad++;
        $error("FAIL invariant observed v=%b idx=%0d oh=%b", grant_valid, grant_idx,
               grant_onehot);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    step();
    check("reset_a", 1'b0, 2'd0);
    step();
    check("reset_b", 1'b0, 2'd0);
    inv_on = 1'b1;
    reset  = 1'b0;

    // Full contention: each owner holds exactly MH cycles, in order.
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("rotate_%0d", c), 1'b1, 2'((c / MH) % N));
    end

    // Single requester: hold saturates, no preemption.
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("single_%0d", c), 1'b1, 2'd2);
    end
    req = 4'b0000;
    step();
    check("go_idle", 1'b0, 2'd0);

    // ptr=3 after granting 2: pick(3) over 0010 finds 1.
    req = 4'b0010;
    step();
    check("own1", 1'b1, 2'd1);
    req = 4'b1000;
    step();
    check("handover3", 1'b1, 2'd3);

    // Owner 2 at hold_cnt=1, then a one-cycle reset with everybody requesting.
    req = 4'b0100;
    step();
    check("own2_h0", 1'b1, 2'd2);
    step();
    check("own2_h1", 1'b1, 2'd2);
    reset = 1'b1;
    req   = 4'b1111;
    step();
    check("mid_reset", 1'b0, 2'd0);
    reset = 1'b0;
    step();
    check("post_reset", 1'b1, 2'd0);

    // Owner 0 with ptr=1: move to owner 2 at hold_cnt=0 (ptr becomes 3).
    req = 4'b0100;
    step();
    check("pre_prio", 1'b1, 2'd2);
    req = 4'b1101;
`ifdef ARB_PRIO0_EN
    step();
    check("prio_take", 1'b1, 2'd0);
    req = 4'b1100;
    step();
    check("prio_ptr_kept", 1'b1, 2'd3);
`else
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold2_%0d", c), 1'b1, 2'd2);
    end
    step();
    check("hold_expire", 1'b1, 2'd3);
`endif

    req = 4'b0000;
    step();
    check("final_idle", 1'b0, 2'd0);
    inv_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
